// File: rtl/ksa_bist_checker.sv
// Built-in self-test sweep for the Kogge-Stone adder: drives every operand pair, checks {cout,sum}.
// Optional first-failure capture ports/registers are enabled by defining KSA_BIST_FIRST_FAIL_EN.
module ksa_bist_checker #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned ERR_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               start,
    output logic [WIDTH-1:0]   op_a,
    output logic [WIDTH-1:0]   op_b,
    input  logic [WIDTH-1:0]   dut_sum,
    input  logic               dut_cout,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [ERR_W-1:0]   err_count
`ifdef KSA_BIST_FIRST_FAIL_EN
    ,
    output logic               first_fail_valid,
    output logic [2*WIDTH-1:0] first_fail_idx,
    output logic [WIDTH:0]     first_fail_obs
`endif
);

    localparam int unsigned IDX_W = 2 * WIDTH;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic [WIDTH:0]     expected, observed;
    logic               mismatch, launch, last_vec;

    // The operand registers are the two halves of the sweep index.
    assign op_a = idx_q[WIDTH-1:0];
    assign op_b = idx_q[IDX_W-1:WIDTH];

    always_comb begin
        expected = {1'b0, op_a} + {1'b0, op_b};
        observed = {dut_cout, dut_sum};
        mismatch = (state_q == S_CHECK) && (expected != observed);
        launch   = ena && start && ((state_q == S_IDLE) || (state_q == S_DONE));
        last_vec = &idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: if (start) state_d = S_DRIVE;
                S_DRIVE:        state_d = (LATENCY > 0) ? S_WAIT : S_CHECK;
                S_WAIT:         if (cnt_q == LAT_LAST) state_d = S_CHECK;
                S_CHECK:        state_d = last_vec ? S_DONE : S_DRIVE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == S_DRIVE) || (state_q == S_WAIT) || (state_q == S_CHECK);
        done      = (state_q == S_DONE);
        pass      = done && (err_q == '0);
        err_count = err_q;
    end

    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (launch) begin
            idx_d = '0;
            err_d = '0;
        end else if (ena) begin
            case (state_q)
                S_DRIVE: cnt_d = '0;
                S_WAIT:  cnt_d = cnt_q + CNT_W'(1);
                S_CHECK: begin
                    if (mismatch && !(&err_q)) err_d = err_q + ERR_W'(1);
                    if (!last_vec)             idx_d = idx_q + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

`ifdef KSA_BIST_FIRST_FAIL_EN
    logic             ff_valid_q, ff_valid_d;
    logic [IDX_W-1:0] ff_idx_q, ff_idx_d;
    logic [WIDTH:0]   ff_obs_q, ff_obs_d;

    always_comb begin
        ff_valid_d = ff_valid_q;
        ff_idx_d   = ff_idx_q;
        ff_obs_d   = ff_obs_q;
        if (launch) begin
            ff_valid_d = 1'b0;
            ff_idx_d   = '0;
            ff_obs_d   = '0;
        end else if (ena && mismatch && !ff_valid_q) begin
            ff_valid_d = 1'b1;
            ff_idx_d   = idx_q;
            ff_obs_d   = observed;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_valid_q <= 1'b0;
            ff_idx_q   <= '0;
            ff_obs_q   <= '0;
        end else begin
            ff_valid_q <= ff_valid_d;
            ff_idx_q   <= ff_idx_d;
            ff_obs_q   <= ff_obs_d;
        end
    end

    assign first_fail_valid = ff_valid_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_obs   = ff_obs_q;
`endif

endmodule

// File: tb/tb_ksa_bist_checker.sv
// Directed bench for ksa_bist_checker with a behavioural adder that can inject fixed faults.
// First-failure checks are compiled in when KSA_BIST_FIRST_FAIL_EN is defined.
module tb_ksa_bist_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op_a, op_b, dut_sum;
    logic       dut_cout, busy, done, pass;
    logic [7:0] err_count;
    logic [4:0] true_sum, fault_sum;
    int         mode = 0;
    int         n_vec = 0;
    int         n_err = 0;
    int         edges;
`ifdef KSA_BIST_FIRST_FAIL_EN
    logic       first_fail_valid;
    logic [7:0] first_fail_idx;
    logic [4:0] first_fail_obs;
`endif

    always #5 clk = ~clk;

    // mode 0: correct, 1: sum[0] stuck 0, 2: cout stuck 0, 3: {cout,sum} inverted
    always_comb begin
        true_sum  = {1'b0, op_a} + {1'b0, op_b};
        fault_sum = true_sum;
        case (mode)
            1: fault_sum = {true_sum[4:1], 1'b0};
            2: fault_sum = {1'b0, true_sum[3:0]};
            3: fault_sum = ~true_sum;
            default: ;
        endcase
        {dut_cout, dut_sum} = fault_sum;
    end

    ksa_bist_checker #(.WIDTH(4), .LATENCY(1), .ERR_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .dut_sum   (dut_sum),
        .dut_cout  (dut_cout),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
`ifdef KSA_BIST_FIRST_FAIL_EN
        ,
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx),
        .first_fail_obs   (first_fail_obs)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Counts edges until done rises, bounded so a stuck FSM still reaches the summary.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 2000) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        // Reset state
        tick(1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        rst_n = 1'b1;
        tick(2);
        chk("idle_busy", busy, 0);

        // Correct adder: full sweep in 768 edges
        mode = 0;
        start_pulse();
        chk("s1_busy", busy, 1);
        wait_done(edges);
        chk("s1_edges", edges, 768);
        chk("s1_done", done, 1);
        chk("s1_busy_end", busy, 0);
        chk("s1_pass", pass, 1);
        chk("s1_err", err_count, 0);
        chk("s1_op_a", op_a, 15);
        chk("s1_op_b", op_b, 15);
        tick(5);
        chk("s1_done_held", done, 1);

        // sum[0] stuck at 0, with a start pulse at cycle 50 that must be ignored
        mode = 1;
        start_pulse();
        tick(49);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("s2_busy", busy, 1);
        wait_done(edges);
        chk("s2_edges", edges, 718);
        chk("s2_err", err_count, 128);
        chk("s2_pass", pass, 0);
`ifdef KSA_BIST_FIRST_FAIL_EN
        chk("s2_ff_valid", first_fail_valid, 1);
        chk("s2_ff_idx", first_fail_idx, 1);
        chk("s2_ff_obs", first_fail_obs, 0);
`endif

        // carry-out stuck at 0
        mode = 2;
        start_pulse();
        wait_done(edges);
        chk("s3_edges", edges, 768);
        chk("s3_err", err_count, 120);
        chk("s3_pass", pass, 0);
`ifdef KSA_BIST_FIRST_FAIL_EN
        chk("s3_ff_idx", first_fail_idx, 31);
        chk("s3_ff_obs", first_fail_obs, 0);
`endif

        // every vector wrong: counter saturates
        mode = 3;
        start_pulse();
        wait_done(edges);
        chk("s4_edges", edges, 768);
        chk("s4_err", err_count, 255);
        chk("s4_pass", pass, 0);
`ifdef KSA_BIST_FIRST_FAIL_EN
        chk("s4_ff_idx", first_fail_idx, 0);
        chk("s4_ff_obs", first_fail_obs, 5'h1F);
`endif

        // start held high in DONE restarts on the next edge; extra start ignored while busy
        start = 1'b1;
        tick(1);
        chk("rs_busy", busy, 1);
        chk("rs_done", done, 0);
        chk("rs_err", err_count, 0);
        chk("rs_op_a", op_a, 0);
        tick(1);
        start = 1'b0;
        chk("rs_busy2", busy, 1);
        tick(98);
        chk("rs_err100", err_count, 33);

        // asynchronous reset at cycle 100
        rst_n = 1'b0;
        #1;
        chk("ar_busy", busy, 0);
        chk("ar_done", done, 0);
        chk("ar_op_a", op_a, 0);
        chk("ar_op_b", op_b, 0);
        chk("ar_err", err_count, 0);
`ifdef KSA_BIST_FIRST_FAIL_EN
        chk("ar_ff_valid", first_fail_valid, 0);
`endif
        #2;
        rst_n = 1'b1;
        tick(3);
        chk("ar_idle", busy, 0);

        // ena low for 20 cycles mid-sweep delays done by 20
        mode = 0;
        start_pulse();
        tick(200);
        chk("en_op_a", op_a, 2);
        chk("en_op_b", op_b, 4);
        ena = 1'b0;
        tick(20);
        chk("en_hold_op_a", op_a, 2);
        chk("en_hold_op_b", op_b, 4);
        chk("en_hold_busy", busy, 1);
        ena = 1'b1;
        wait_done(edges);
        chk("en_edges", edges, 568);
        chk("en_pass", pass, 1);
        chk("en_err", err_count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ksa_bist_checker.md
Name: ksa_bist_checker

Overview:
Sequential stimulus generator and response checker for the combinational Kogge-Stone adder. It drives every operand pair onto the adder's operand inputs and captures the adder's sum and carry-out. It compares each result against an internal reference sum, counts mismatches and reports pass/fail. It sits beside the adder inside the tile as a built-in self-test and can also drive an external adder through the IO pins.

Parameters:
WIDTH, 4, operand width in bits; sweep covers 2^(2*WIDTH) vectors
LATENCY, 1, settle cycles between driving operands and sampling the result (0 allowed)
ERR_W, 8, width of saturating error counter

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; low freezes all state
start  input  1  begin sweep; sampled only in IDLE
op_a  output  WIDTH  operand A to adder (registered)
op_b  output  WIDTH  operand B to adder (registered)
dut_sum  input  WIDTH  adder sum result
dut_cout  input  1  adder carry-out
busy  output  1  sweep in progress
done  output  1  sweep complete; held until next start or reset
pass  output  1  done and zero errors
err_count  output  ERR_W  mismatch count, saturating

Behaviour:
- Reset (async, rst_n=0): state=IDLE; idx=0; op_a=op_b=0; busy=done=pass=0; err_count=0. Reset mid-sweep aborts immediately. No partial results are retained.
- ena=0: all registers hold, including state, idx, counters and the wait counter. start is ignored.
- FSM states and transitions:
  - IDLE: busy=0. On start=1 and ena=1 at an edge: clear err_count, clear done/pass, idx=0, go to DRIVE.
  - DONE: on start=1, same transition as from IDLE.
- Index and operands: idx is 2*WIDTH bits. On entering DRIVE, op_a=idx[WIDTH-1:0] and op_b=idx[2*WIDTH-1:WIDTH]. The operands are held stable through WAIT and CHECK.
- DRIVE: 1 cycle; busy=1. Next state is WAIT if LATENCY>0, else CHECK.
- WAIT: exactly LATENCY cycles, counted by an internal counter, then CHECK.
- CHECK: 1 cycle.
  - Expected value = op_a + op_b, computed at WIDTH+1 bits with the MSB as carry.
  - Compare it with {dut_cout, dut_sum} at the edge leaving CHECK.
  - On mismatch, err_count increments unless already all-ones (saturates, no wrap).
  - If idx is all-ones, go to DONE. Otherwise idx increments and the FSM goes to DRIVE.
- Vector timing: each vector costs 2+LATENCY cycles. With defaults, DONE is entered exactly 768 edges after the edge that sampled start.
- DONE: busy=0, done=1, pass=(err_count==0). Operands hold their last value (all-ones).
- start while busy: ignored, with no restart and no effect on counters.
- start held high continuously: after DONE, the sweep restarts on the next edge.

Optional Feature:
Macro KSA_BIST_FIRST_FAIL_EN.
- With the macro: adds outputs first_fail_valid (1), first_fail_idx (2*WIDTH) and first_fail_obs (WIDTH+1).
  - On the first mismatch of a sweep, they capture idx and {dut_cout,dut_sum}, and first_fail_valid is set.
  - Later mismatches do not overwrite them.
  - All three are cleared on reset and on sweep start.
- Without the macro: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Correct adder model connected, defaults, start pulse -> busy high for 768 cycles, then done=1, pass=1, err_count=0, op_a=op_b=15.
- Adder with sum[0] stuck at 0 -> err_count=128, pass=0. With KSA_BIST_FIRST_FAIL_EN: first_fail_idx=1 (a=1,b=0), first_fail_obs=0.
- Adder with carry-out stuck at 0 -> err_count=120 (pairs with a+b>=16), pass=0.
- Adder output inverted (every vector wrong) -> 256 mismatches, err_count saturates at 255, pass=0.
- Start pulse re-asserted at cycle 50 of a sweep -> ignored; done still rises at cycle 768 with unchanged counts.
- rst_n low at cycle 100 -> immediately busy=0, op_a=op_b=0, err_count=0, state IDLE.
- ena low for 20 cycles mid-sweep -> all outputs hold; done is delayed by exactly 20 cycles.
